weight_bank_pingpong: RTL and testbench
=======================================

# weight_bank_pingpong

Double-buffered, multi-lane weight store for the CNN datapath, successor to the single-bank weight register file. The SPI loader streams weights into the shadow bank with an auto-incrementing pointer and a valid/ready handshake, while the CNN reads NUM_LANES consecutive weights per cycle from the active bank. A swap handshake promotes a fully loaded shadow bank to active, so the next layer's weights load while the current layer computes. A load count, a checksum and a sticky overflow flag let firmware verify each load.

## Interface
- DATAWIDTH_BUS, 8: weight width in bits.
- ADDRESS_WIDTH, 16: address width; must satisfy 2^ADDRESS_WIDTH ≥ NUM_WEIGHTS.
- NUM_WEIGHTS, 10422: depth of each bank.
- NUM_LANES, 4: weights returned per read; must be ≥ 1.
- CHECK_WIDTH, 16: width of the load checksum.

Ports (name, direction, width, meaning):
- WBuf_Clock_In_Data  in  1  single clock; all logic on posedge.
- WBuf_Reset_InHigh  in  1  synchronous reset, active-high.
- WBuf_LoadStart_In_Data  in  1  one-cycle pulse; opens a load at WBuf_LoadBase_In_DataBUS.
- WBuf_LoadBase_In_DataBUS  in  ADDRESS_WIDTH  start address of the load.
- WBuf_LoadData_In_DataBUS  in  DATAWIDTH_BUS  weight beat.
- WBuf_LoadValid_In_Data  in  1  beat valid.
- WBuf_LoadReady_Out_Data  out  1  high in LOADING only.
- WBuf_LoadDone_In_Data  in  1  one-cycle pulse; closes the load.
- WBuf_LoadCount_Out_DataBUS  out  ADDRESS_WIDTH+1  beats written in the current or last load.
- WBuf_LoadChecksum_Out_DataBUS  out  CHECK_WIDTH  sum of written beats, mod 2^CHECK_WIDTH.
- WBuf_Error_Out_Data  out  1  sticky overflow flag.
- WBuf_ShadowFull_Out_Data  out  1  high in FULL.
- WBuf_Swap_In_Data  in  1  one-cycle pulse; requests a bank swap.
- WBuf_ActiveBank_Out_Data  out  1  index of the active bank.
- WBuf_ReadEn_In_Data  in  1  read request.
- WBuf_ReadAddr_In_DataBUS  in  ADDRESS_WIDTH  base read address.
- WBuf_ReadData_Out_DataBUS  out  NUM_LANES*DATAWIDTH_BUS  lane k in bits [k*DW +: DW].
- WBuf_ReadValid_Out_Data  out  1  read data valid.

## Operation
- Storage: two banks of NUM_WEIGHTS x DATAWIDTH_BUS. Memory contents are not reset.
- The shadow bank is the bank that is not active.

Load FSM states and transitions:
- IDLE:
  - LoadStart -> LOADING: ptr=Base, count=0, checksum=0, Error=0.
- LOADING (Ready=1):
  - Beat accepted when Valid=1 and Ready=1.
  - If ptr < NUM_WEIGHTS: shadow[ptr]=Data, count+1, checksum += zero-extended Data.
  - If ptr ≥ NUM_WEIGHTS: beat dropped, Error=1, count and checksum unchanged.
  - ptr always increments after an accepted beat; saturates at all-ones, no wrap.
  - LoadDone -> FULL. A beat in the same cycle as LoadDone is accepted first.
  - LoadStart restarts the load with the same effects as from IDLE. Restart takes priority over LoadDone.
- FULL:
  - Swap -> IDLE and ActiveBank toggles.
  - LoadStart -> LOADING. The shadow bank is overwritten and ShadowFull drops.
  - LoadStart and Swap in the same cycle: swap first, then the load opens into the new shadow bank; next state LOADING.
- Swap in IDLE or LOADING is ignored, with no flag.
- Valid without Ready (IDLE or FULL): data is ignored.

Read path:
- ReadEn registers lane k = active[Addr+k]. Compute the sum in ADDRESS_WIDTH+1 bits; lane = 0 when Addr+k ≥ NUM_WEIGHTS.
- ReadData holds its last value when ReadEn=0.
- Reads never see the shadow bank. Loads never touch the active bank.

## Timing
- Reset values: state IDLE, ActiveBank 0, Ready 0, ShadowFull 0, Error 0, count 0, checksum 0, ReadValid 0, ReadData 0.
- Reset mid-load aborts the load. Shadow contents are then undefined for verification purposes.
- Read latency is 1 cycle: ReadEn at edge N gives ReadData/ReadValid after edge N+1; throughput is one read per cycle.
- A read sampled at the swap edge uses the pre-swap active bank. Reads from the next cycle use the new bank.
- Ready rises the cycle after LoadStart is sampled and falls the cycle after LoadDone is sampled.
- ShadowFull rises the cycle after LoadDone is sampled and falls the cycle after Swap or LoadStart is sampled.
- Count, checksum and Error update in the cycle after the beat.
- Count, checksum and Error hold their values through FULL and IDLE until the next LoadStart.

## Test plan
- Reset, then load 5 beats 0x01..0x05 at base 0, then LoadDone:
  - Count=5, checksum=0x000F, ShadowFull=1.
  - Reads of address 0 still return the old active bank (all lanes 0 after a memory init-to-0).
- Swap, then ReadEn with Addr=0 (NUM_LANES=4):
  - ActiveBank=1 next cycle.
  - One cycle later ReadData lanes = 01,02,03,04 and ReadValid=1.
- Read with Addr=NUM_WEIGHTS-2: lanes 0..1 carry data, lanes 2..3 = 0.
- Load at base NUM_WEIGHTS-1 with 3 beats:
  - The first beat is written; the second and third are dropped.
  - Error=1 and count=1.
  - The next LoadStart clears Error.
- Swap pulse in IDLE and in LOADING: ActiveBank unchanged, no effect.
- Assert reset mid-load after 2 beats: Ready=0, state IDLE, count=0, and ActiveBank=0 on the next cycle.
- Back-to-back reads on an incrementing address for 8 cycles, with a swap in cycle 4:
  - Data is from the old bank for reads sampled at edges ≤ 4, and from the new bank after.
  - ReadValid is continuous.

Source files
------------

// File: rtl/weight_bank_pingpong_if.sv
// Bundle of load, swap and read signals for weight_bank_pingpong.
// The master drives the loader/reader side and the slave is the weight bank.
//   Load : LoadStart/LoadBase/LoadData/LoadValid/LoadDone in, LoadReady out
//   Stats: LoadCount, LoadChecksum, Error, ShadowFull out
//   Swap : Swap in, ActiveBank out
//   Read : ReadEn/ReadAddr in, ReadData/ReadValid out
interface weight_bank_pingpong_if #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int ADDRESS_WIDTH = 16,
  parameter int NUM_LANES     = 4,
  parameter int CHECK_WIDTH   = 16
);
  logic                               WBuf_LoadStart_In_Data;
  logic [ADDRESS_WIDTH-1:0]           WBuf_LoadBase_In_DataBUS;
  logic [DATAWIDTH_BUS-1:0]           WBuf_LoadData_In_DataBUS;
  logic                               WBuf_LoadValid_In_Data;
  logic                               WBuf_LoadReady_Out_Data;
  logic                               WBuf_LoadDone_In_Data;
  logic [ADDRESS_WIDTH:0]             WBuf_LoadCount_Out_DataBUS;
  logic [CHECK_WIDTH-1:0]             WBuf_LoadChecksum_Out_DataBUS;
  logic                               WBuf_Error_Out_Data;
  logic                               WBuf_ShadowFull_Out_Data;
  logic                               WBuf_Swap_In_Data;
  logic                               WBuf_ActiveBank_Out_Data;
  logic                               WBuf_ReadEn_In_Data;
  logic [ADDRESS_WIDTH-1:0]           WBuf_ReadAddr_In_DataBUS;
  logic [NUM_LANES*DATAWIDTH_BUS-1:0] WBuf_ReadData_Out_DataBUS;
  logic                               WBuf_ReadValid_Out_Data;

  modport master (
    output WBuf_LoadStart_In_Data, WBuf_LoadBase_In_DataBUS, WBuf_LoadData_In_DataBUS,
           WBuf_LoadValid_In_Data, WBuf_LoadDone_In_Data, WBuf_Swap_In_Data,
           WBuf_ReadEn_In_Data, WBuf_ReadAddr_In_DataBUS,
    input  WBuf_LoadReady_Out_Data, WBuf_LoadCount_Out_DataBUS, WBuf_LoadChecksum_Out_DataBUS,
           WBuf_Error_Out_Data, WBuf_ShadowFull_Out_Data, WBuf_ActiveBank_Out_Data,
           WBuf_ReadData_Out_DataBUS, WBuf_ReadValid_Out_Data
  );

  modport slave (
    input  WBuf_LoadStart_In_Data, WBuf_LoadBase_In_DataBUS, WBuf_LoadData_In_DataBUS,
           WBuf_LoadValid_In_Data, WBuf_LoadDone_In_Data, WBuf_Swap_In_Data,
           WBuf_ReadEn_In_Data, WBuf_ReadAddr_In_DataBUS,
    output WBuf_LoadReady_Out_Data, WBuf_LoadCount_Out_DataBUS, WBuf_LoadChecksum_Out_DataBUS,
           WBuf_Error_Out_Data, WBuf_ShadowFull_Out_Data, WBuf_ActiveBank_Out_Data,
           WBuf_ReadData_Out_DataBUS, WBuf_ReadValid_Out_Data
  );
endinterface

// File: rtl/weight_bank_pingpong.sv
// Double-buffered weight store. The loader streams beats into the shadow bank
// through an auto-incrementing pointer; the CNN reads NUM_LANES consecutive
// weights per cycle from the active bank; a swap promotes a full shadow bank.
// Ports:
//   WBuf_Clock_In_Data  clock, posedge
//   WBuf_Reset_InHigh   synchronous reset, active-high
//   bus                 load / swap / read signals (slave side)
//
// Load FSM
//   state     | meaning
//   S_IDLE    | no load open; beats ignored
//   S_LOADING | load open, Ready=1, beats written to shadow bank
//   S_FULL    | load closed, shadow bank waiting for a swap
module weight_bank_pingpong #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int ADDRESS_WIDTH = 16,
  parameter int NUM_WEIGHTS   = 10422,
  parameter int NUM_LANES     = 4,
  parameter int CHECK_WIDTH   = 16
) (
  input logic                   WBuf_Clock_In_Data,
  input logic                   WBuf_Reset_InHigh,
  weight_bank_pingpong_if.slave bus
);
  localparam int DW = DATAWIDTH_BUS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = $clog2(NUM_WEIGHTS);
  localparam logic [AW:0] NW_L = (AW+1)'(NUM_WEIGHTS);

  typedef enum logic [1:0] {S_IDLE, S_LOADING, S_FULL} state_e;

  state_e                  state_q;
  logic                    active_q;
  logic                    ready_q;
  logic                    full_q;
  logic                    err_q;
  logic [AW-1:0]           ptr_q;
  logic [AW:0]             count_q;
  logic [CHECK_WIDTH-1:0]  csum_q;
  logic                    rvalid_q;
  logic [NUM_LANES*DW-1:0] rdata_q;
  logic [NUM_LANES*DW-1:0] rdata_d;
  logic [DW-1:0]           bank_q [2][NUM_WEIGHTS];

  logic ptr_in_range;
  logic wr_en;

  assign ptr_in_range = ({1'b0, ptr_q} < NW_L);
  // A restart in the same cycle as a beat wins, so that beat is not stored.
  assign wr_en = (state_q == S_LOADING) && bus.WBuf_LoadValid_In_Data &&
                 !bus.WBuf_LoadStart_In_Data && ptr_in_range;

  always_ff @(posedge WBuf_Clock_In_Data) begin
    if (WBuf_Reset_InHigh) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      ready_q  <= 1'b0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      count_q  <= '0;
      csum_q   <= '0;
    end else begin
      // Swap resolves before a simultaneous LoadStart, so the new load lands
      // in the bank that was active until this edge.
      if (state_q == S_FULL && bus.WBuf_Swap_In_Data) begin
        active_q <= ~active_q;
      end
      if (bus.WBuf_LoadStart_In_Data) begin
        state_q <= S_LOADING;
        ready_q <= 1'b1;
        full_q  <= 1'b0;
        err_q   <= 1'b0;
        ptr_q   <= bus.WBuf_LoadBase_In_DataBUS;
        count_q <= '0;
        csum_q  <= '0;
      end else begin
        case (state_q)
          S_LOADING: begin
            if (bus.WBuf_LoadValid_In_Data) begin
              if (ptr_in_range) begin
                count_q <= count_q + (AW+1)'(1);
                csum_q  <= csum_q + CHECK_WIDTH'(bus.WBuf_LoadData_In_DataBUS);
              end else begin
                err_q <= 1'b1;
              end
              if (ptr_q != '1) begin
                ptr_q <= ptr_q + AW'(1);
              end
            end
            if (bus.WBuf_LoadDone_In_Data) begin
              state_q <= S_FULL;
              ready_q <= 1'b0;
              full_q  <= 1'b1;
            end
          end
          S_FULL: begin
            if (bus.WBuf_Swap_In_Data) begin
              state_q <= S_IDLE;
              full_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge WBuf_Clock_In_Data) begin
    if (wr_en) begin
      bank_q[~active_q][ptr_q[IW-1:0]] <= bus.WBuf_LoadData_In_DataBUS;
    end
  end

  // Lane addresses are formed one bit wider than the port so that reads near
  // the top of the address space return zero instead of wrapping.
  always_comb begin
    logic [AW:0] lane_addr;
    rdata_d   = '0;
    lane_addr = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_addr = {1'b0, bus.WBuf_ReadAddr_In_DataBUS} + (AW+1)'(k);
      if (lane_addr < NW_L) begin
        rdata_d[k*DW +: DW] = bank_q[active_q][lane_addr[IW-1:0]];
      end
    end
  end

  always_ff @(posedge WBuf_Clock_In_Data) begin
    if (WBuf_Reset_InHigh) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.WBuf_ReadEn_In_Data;
      if (bus.WBuf_ReadEn_In_Data) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign bus.WBuf_LoadReady_Out_Data       = ready_q;
  assign bus.WBuf_ShadowFull_Out_Data      = full_q;
  assign bus.WBuf_Error_Out_Data           = err_q;
  assign bus.WBuf_LoadCount_Out_DataBUS    = count_q;
  assign bus.WBuf_LoadChecksum_Out_DataBUS = csum_q;
  assign bus.WBuf_ActiveBank_Out_Data      = active_q;
  assign bus.WBuf_ReadData_Out_DataBUS     = rdata_q;
  assign bus.WBuf_ReadValid_Out_Data       = rvalid_q;
endmodule

// File: tb/tb_weight_bank_pingpong.sv
// Scoreboard bench for weight_bank_pingpong: a reference model pushes expected
// status and read data at each clock edge; a monitor pops and compares.
module tb_weight_bank_pingpong;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NW = 10422;
  localparam int NL = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_bank_pingpong_if #(.DATAWIDTH_BUS(DW), .ADDRESS_WIDTH(AW),
                            .NUM_LANES(NL), .CHECK_WIDTH(CW)) bus ();

  weight_bank_pingpong #(.DATAWIDTH_BUS(DW), .ADDRESS_WIDTH(AW), .NUM_WEIGHTS(NW),
                         .NUM_LANES(NL), .CHECK_WIDTH(CW)) dut (
    .WBuf_Clock_In_Data(clk),
    .WBuf_Reset_InHigh (rst),
    .bus               (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit ready, full, active, err, rvalid;
    int count, csum;
  } st_t;
  typedef struct {
    logic [NL*DW-1:0] data;
    logic [NL*DW-1:0] mask;
  } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];

  // Reference model: bank contents plus a "known" flag per word.
  byte unsigned mb [2][NW];
  bit           mk [2][NW];
  int m_mode = 0;            // 0 no load, 1 load open, 2 shadow full
  bit m_active = 0;
  bit m_err = 0;
  int m_ptr = 0, m_count = 0, m_sum = 0;

  always @(posedge clk) begin
    st_t s;
    rd_t r;
    int  a;
    if (rst) begin
      for (int i = 0; i < NW; i++) mk[!m_active][i] = 0;
      m_mode = 0; m_active = 0; m_err = 0; m_ptr = 0; m_count = 0; m_sum = 0;
      rd_q.delete();
      s.rvalid = 0;
    end else begin
      s.rvalid = bus.WBuf_ReadEn_In_Data;
      if (bus.WBuf_ReadEn_In_Data) begin
        r.data = '0;
        r.mask = '0;
        for (int k = 0; k < NL; k++) begin
          a = int'(bus.WBuf_ReadAddr_In_DataBUS) + k;
          if (a >= NW) begin
            r.mask[k*DW +: DW] = '1;
          end else if (mk[m_active][a]) begin
            r.data[k*DW +: DW] = mb[m_active][a];
            r.mask[k*DW +: DW] = '1;
          end
        end
        rd_q.push_back(r);
      end
      if (m_mode == 2 && bus.WBuf_Swap_In_Data) begin
        m_active = !m_active;
        m_mode = 0;
      end
      if (bus.WBuf_LoadStart_In_Data) begin
        m_mode = 1; m_ptr = int'(bus.WBuf_LoadBase_In_DataBUS);
        m_count = 0; m_sum = 0; m_err = 0;
      end else if (m_mode == 1) begin
        if (bus.WBuf_LoadValid_In_Data) begin
          if (m_ptr < NW) begin
            mb[!m_active][m_ptr] = bus.WBuf_LoadData_In_DataBUS;
            mk[!m_active][m_ptr] = 1;
            m_count++;
            m_sum = (m_sum + int'(bus.WBuf_LoadData_In_DataBUS)) % (1 << CW);
          end else begin
            m_err = 1;
          end
          if (m_ptr < (1 << AW) - 1) m_ptr++;
        end
        if (bus.WBuf_LoadDone_In_Data) m_mode = 2;
      end
    end
    s.ready = (m_mode == 1); s.full = (m_mode == 2); s.active = m_active;
    s.err = m_err; s.count = m_count; s.csum = m_sum;
    st_q.push_back(s);
  end

  // Monitor: one status comparison per cycle, one data comparison per valid read.
  always @(negedge clk) begin
    st_t e;
    rd_t r;
    if (st_q.size() != 0) begin
      e = st_q.pop_front();
      checks++;
      if (bus.WBuf_LoadReady_Out_Data !== e.ready || bus.WBuf_ShadowFull_Out_Data !== e.full ||
          bus.WBuf_ActiveBank_Out_Data !== e.active || bus.WBuf_Error_Out_Data !== e.err ||
          bus.WBuf_ReadValid_Out_Data !== e.rvalid ||
          bus.WBuf_LoadCount_Out_DataBUS !== (AW+1)'(e.count) ||
          bus.WBuf_LoadChecksum_Out_DataBUS !== CW'(e.csum)) begin
        errors++;
        $display("FAIL status @%0t: got rdy=%b full=%b act=%b err=%b rv=%b cnt=%0d sum=%h; want rdy=%b full=%b act=%b err=%b rv=%b cnt=%0d sum=%h",
                 $time, bus.WBuf_LoadReady_Out_Data, bus.WBuf_ShadowFull_Out_Data,
                 bus.WBuf_ActiveBank_Out_Data, bus.WBuf_Error_Out_Data, bus.WBuf_ReadValid_Out_Data,
                 bus.WBuf_LoadCount_Out_DataBUS, bus.WBuf_LoadChecksum_Out_DataBUS,
                 e.ready, e.full, e.active, e.err, e.rvalid, e.count, CW'(e.csum));
      end
    end
    if (bus.WBuf_ReadValid_Out_Data === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_data @%0t: got unexpected valid read, want no read pending", $time);
      end else begin
        r = rd_q.pop_front();
        if (((bus.WBuf_ReadData_Out_DataBUS ^ r.data) & r.mask) != '0) begin
          errors++;
          $display("FAIL read_data @%0t: got %h want %h (mask %h)", $time,
                   bus.WBuf_ReadData_Out_DataBUS, r.data, r.mask);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 2 time units after the edge.
  task automatic cyc(input bit st, input int base, input int d, input bit v,
                     input bit dn, input bit sw, input bit re, input int ra);
    bus.WBuf_LoadStart_In_Data   = st;
    bus.WBuf_LoadBase_In_DataBUS = AW'(base);
    bus.WBuf_LoadData_In_DataBUS = DW'(d);
    bus.WBuf_LoadValid_In_Data   = v;
    bus.WBuf_LoadDone_In_Data    = dn;
    bus.WBuf_Swap_In_Data        = sw;
    bus.WBuf_ReadEn_In_Data      = re;
    bus.WBuf_ReadAddr_In_DataBUS = AW'(ra);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();           cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic start(input int b); cyc(1, b, 0, 0, 0, 0, 0, 0); endtask
  task automatic beat(input int d);  cyc(0, 0, d, 1, 0, 0, 0, 0); endtask
  task automatic done();           cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic swap();           cyc(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic rd(input int a);  cyc(0, 0, 0, 0, 0, 0, 1, a); endtask

  initial begin
    rst = 1'b1;
    repeat (3) idle();
    chk("reset_rdata", bus.WBuf_ReadData_Out_DataBUS, 0);
    chk("reset_rvalid", bus.WBuf_ReadValid_Out_Data, 0);
    chk("reset_ready", bus.WBuf_LoadReady_Out_Data, 0);
    chk("reset_active", bus.WBuf_ActiveBank_Out_Data, 0);
    chk("reset_count", bus.WBuf_LoadCount_Out_DataBUS, 0);
    rst = 1'b0;
    idle();

    // Five beats at base 0 into the shadow bank.
    start(0);
    for (int d = 1; d <= 5; d++) beat(d);
    done();
    chk("load5_count", bus.WBuf_LoadCount_Out_DataBUS, 5);
    chk("load5_checksum", bus.WBuf_LoadChecksum_Out_DataBUS, 'h000F);
    chk("load5_full", bus.WBuf_ShadowFull_Out_Data, 1);
    rd(0);
    idle();

    swap();
    chk("swap_active", bus.WBuf_ActiveBank_Out_Data, 1);
    rd(0);
    chk("read_after_swap", bus.WBuf_ReadData_Out_DataBUS, 'h04030201);
    chk("read_after_swap_valid", bus.WBuf_ReadValid_Out_Data, 1);
    idle();

    // Top-of-bank read: upper lanes fall off the end and read zero.
    start(NW - 4);
    for (int d = 'h11; d <= 'h14; d++) beat(d);
    done();
    swap();
    chk("swap_back_active", bus.WBuf_ActiveBank_Out_Data, 0);
    rd(NW - 2);
    chk("read_top_lanes", bus.WBuf_ReadData_Out_DataBUS, 'h00001413);

    // Overflow: only the first beat fits.
    start(NW - 1);
    beat('hA0); beat('hA1); beat('hA2);
    chk("overflow_err", bus.WBuf_Error_Out_Data, 1);
    chk("overflow_count", bus.WBuf_LoadCount_Out_DataBUS, 1);
    chk("overflow_checksum", bus.WBuf_LoadChecksum_Out_DataBUS, 'hA0);
    done();
    chk("overflow_err_held", bus.WBuf_Error_Out_Data, 1);
    start(0);
    chk("restart_clears_err", bus.WBuf_Error_Out_Data, 0);

    // Swap ignored while loading and while idle.
    swap();
    chk("swap_in_loading", bus.WBuf_ActiveBank_Out_Data, 0);
    done();
    swap();
    chk("swap_from_full", bus.WBuf_ActiveBank_Out_Data, 1);
    swap();
    chk("swap_in_idle", bus.WBuf_ActiveBank_Out_Data, 1);

    // Reset in the middle of a load.
    start(100);
    beat(7); beat(8);
    rst = 1'b1;
    idle();
    chk("midreset_ready", bus.WBuf_LoadReady_Out_Data, 0);
    chk("midreset_full", bus.WBuf_ShadowFull_Out_Data, 0);
    chk("midreset_count", bus.WBuf_LoadCount_Out_DataBUS, 0);
    chk("midreset_active", bus.WBuf_ActiveBank_Out_Data, 0);
    rst = 1'b0;
    idle();

    // Fill both banks, then stream reads with a swap on the fourth read.
    start(0);
    for (int i = 0; i < 12; i++) beat($urandom_range(255));
    done();
    swap();
    start(0);
    for (int i = 0; i < 12; i++) beat($urandom_range(255));
    done();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, (i == 3), 1, i);
    chk("stream_active", bus.WBuf_ActiveBank_Out_Data, 0);
    idle(); idle();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit st, dn, sw, v, re;
      int base, ra;
      st = ($urandom_range(99) < 3);
      dn = ($urandom_range(99) < 4);
      sw = ($urandom_range(99) < 6);
      v  = ($urandom_range(99) < 70);
      re = ($urandom_range(99) < 50);
      case ($urandom_range(3))
        0:       base = $urandom_range(30);
        1:       base = NW - $urandom_range(8, 1);
        2:       base = $urandom_range(65535);
        default: base = 65535 - $urandom_range(3);
      endcase
      case ($urandom_range(3))
        0:       ra = $urandom_range(40);
        1:       ra = NW - $urandom_range(6, 1);
        2:       ra = $urandom_range(NW - 1);
        default: ra = 65535 - $urandom_range(3);
      endcase
      cyc(st, base, $urandom_range(255), v, dn, sw, re, ra);
    end

    repeat (4) idle();
    chk("read_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
